// File: rtl/dds_button_ctrl.sv
// Front-panel controller for the DDS function generator.
// Debounces four active-low buttons, turns press events into configuration
// commands (with auto-repeat on up/down) and holds the DDS configuration
// registers: waveform select, frequency tuning word and step exponent.
//
// Handshake: there is no back-pressure. oCfgValid is a one-cycle strobe that
// is high in exactly the cycle the configuration outputs first show the value
// produced by an accepted command (including a saturated, unchanged FTW).
module dds_button_ctrl #(
  parameter int unsigned          FTW_WIDTH    = 32,
  parameter int unsigned          DEB_CYCLES   = 500000,
  parameter int unsigned          REPEAT_DELAY = 25000000,
  parameter int unsigned          REPEAT_RATE  = 5000000,
  parameter logic [FTW_WIDTH-1:0] FTW_INIT     = FTW_WIDTH'(85899),
  parameter logic [FTW_WIDTH-1:0] FTW_MAX      = FTW_WIDTH'(32'h7FFFFFFF),
  parameter logic [FTW_WIDTH-1:0] FTW_MIN      = FTW_WIDTH'(1)
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 iBtnMode,
  input  logic                 iBtnStep,
  input  logic                 iBtnUp,
  input  logic                 iBtnDown,
  output logic [1:0]           oWaveSel,
  output logic [FTW_WIDTH-1:0] oFtw,
  output logic [4:0]           oStepExp,
  output logic                 oCfgValid
);

  // Button indices into the packed button vectors.
  localparam int BTN_MODE = 0;
  localparam int BTN_STEP = 1;
  localparam int BTN_UP   = 2;
  localparam int BTN_DOWN = 3;

  localparam int unsigned DW       = $clog2(DEB_CYCLES);
  localparam int unsigned RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned TW       = $clog2(RPT_MAX) + 1;
  localparam int unsigned EW       = FTW_WIDTH + 1;

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);
  localparam logic [5:0]    EXP_LAST   = 6'(FTW_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  // Direction latched when an up/down press starts a hold.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  logic [3:0]          raw;
  logic [3:0]          deb_q, deb_d;
  logic [3:0]          deb_prev_q;
  logic [3:0][DW-1:0]  cnt_q, cnt_d;
  logic [3:0]          press_ev;

  rpt_state_t          state_q, state_d;
  logic                dir_q, dir_d;
  logic [TW-1:0]       timer_q, timer_d;

  logic [1:0]          wave_q, wave_d;
  logic [FTW_WIDTH-1:0] ftw_q, ftw_d;
  logic [4:0]          exp_q, exp_d;
  logic                cfg_valid_q, cfg_valid_d;

  logic                do_mode, do_step, do_up, do_down;
  logic                ftw_busy, both_held, released, opp_ev;
  logic [TW-1:0]       limit;

  logic [EW-1:0]        step_val, sum, diff;
  logic [FTW_WIDTH-1:0] up_val, down_val;
  logic [5:0]           exp_inc;
  logic [4:0]           exp_next;

  assign raw = {iBtnDown, iBtnUp, iBtnStep, iBtnMode};

  // Press event: debounced level just went from released (1) to pressed (0).
  assign press_ev = deb_prev_q & ~deb_q;

  // Per-button debounce: level only follows raw after DEB_CYCLES stable cycles.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (raw[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        deb_d[i] = raw[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  // FTW / exponent arithmetic, one bit wider so carry and borrow saturate.
  always_comb begin
    step_val = EW'(1) << exp_q;
    sum      = {1'b0, ftw_q} + step_val;
    diff     = {1'b0, ftw_q} - step_val;
    up_val   = (sum > {1'b0, FTW_MAX}) ? FTW_MAX : sum[FTW_WIDTH-1:0];
    down_val = (diff[FTW_WIDTH] || (diff[FTW_WIDTH-1:0] < FTW_MIN)) ? FTW_MIN
                                                                     : diff[FTW_WIDTH-1:0];
    exp_inc  = {1'b0, exp_q} + 6'd4;
    exp_next = (exp_inc > EXP_LAST) ? 5'd0 : exp_inc[4:0];
  end

  // Command arbitration and auto-repeat next-state logic.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    do_mode   = 1'b0;
    do_step   = 1'b0;
    do_up     = 1'b0;
    do_down   = 1'b0;

    // Mode beats Step; either one blocks any FTW change in the same cycle.
    ftw_busy  = press_ev[BTN_MODE] | press_ev[BTN_STEP];
    if (press_ev[BTN_MODE]) begin
      do_mode = 1'b1;
    end else if (press_ev[BTN_STEP]) begin
      do_step = 1'b1;
    end

    both_held = ~deb_q[BTN_UP] & ~deb_q[BTN_DOWN];
    released  = (dir_q == DIR_UP) ? deb_q[BTN_UP] : deb_q[BTN_DOWN];
    opp_ev    = (dir_q == DIR_UP) ? press_ev[BTN_DOWN] : press_ev[BTN_UP];
    limit     = (state_q == ST_HOLD) ? DELAY_LAST : RATE_LAST;

    case (state_q)
      ST_IDLE: begin
        if ((press_ev[BTN_UP] | press_ev[BTN_DOWN]) && !ftw_busy) begin
          if (press_ev[BTN_UP]) begin
            do_up = 1'b1;
            dir_d = DIR_UP;
          end else begin
            do_down = 1'b1;
            dir_d   = DIR_DOWN;
          end
          timer_d = '0;
          // With both up and down held the press runs once but never repeats.
          state_d = both_held ? ST_IDLE : ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (opp_ev || both_held || released) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == limit) begin
          // A Mode/Step command in this cycle swallows the repeat step.
          if (!ftw_busy) begin
            do_up   = (dir_q == DIR_UP);
            do_down = (dir_q == DIR_DOWN);
          end
          timer_d = '0;
          state_d = ST_REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Configuration register next values.
  always_comb begin
    wave_d      = do_mode ? (wave_q + 2'd1) : wave_q;
    exp_d       = do_step ? exp_next : exp_q;
    ftw_d       = ftw_q;
    if (do_up) begin
      ftw_d = up_val;
    end else if (do_down) begin
      ftw_d = down_val;
    end
    cfg_valid_d = do_mode | do_step | do_up | do_down;
  end

  // State registers; reset mid-press forces a full re-debounce.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      deb_q       <= '1;
      deb_prev_q  <= '1;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      dir_q       <= DIR_UP;
      timer_q     <= '0;
      wave_q      <= 2'd0;
      ftw_q       <= FTW_INIT;
      exp_q       <= 5'd0;
      cfg_valid_q <= 1'b0;
    end else begin
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      wave_q      <= wave_d;
      ftw_q       <= ftw_d;
      exp_q       <= exp_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  assign oWaveSel  = wave_q;
  assign oFtw      = ftw_q;
  assign oStepExp  = exp_q;
  assign oCfgValid = cfg_valid_q;

endmodule
